ram_loader: RTL and testbench
=============================

# ram_loader

Write-side counterpart to the team's synchronous 128×16 lookup memory reader. It accepts a burst of 16-bit words over a valid/ready stream, or a single fill value, and writes them into a 128-entry 16-bit RAM. Writes start at a programmable base address, advance with wrap-around, and stop after a programmable length. A registered read port with the same one-cycle latency as the reader lets downstream logic and the bench observe the contents.

## Interface
Parameters:
- DATA_W, 16, word width
- ADDR_W, 7, address width
- DEPTH, 128, number of entries (2**ADDR_W)

Ports:
- clk  in  1  single system clock; all logic on posedge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a job; sampled only in IDLE
- fill  in  1  sampled with start; 1 = fill mode, 0 = stream mode
- base  in  ADDR_W  first write address, sampled with start
- len  in  8  word count, sampled with start; 0 = no writes; values above 128 are clamped to 128
- in_data  in  DATA_W  stream word; in fill mode, the fill value is sampled with start
- in_valid  in  1  stream word valid
- in_ready  out  1  loader accepts a word this cycle
- busy  out  1  high in LOAD, FILL, and DONE
- done  out  1  one-cycle pulse at job end
- wr_cnt  out  8  words written in the current or last job
- rd_addr  in  ADDR_W  read address
- rd_data  out  DATA_W  registered read data

## Operation
- States: IDLE, LOAD, FILL, DONE.
- IDLE to LOAD on start & !fill & len!=0.
- IDLE to FILL on start & fill & len!=0.
- IDLE to DONE on start & len==0.
- start is ignored outside IDLE.
- On start: addr <= base, remaining <= min(len,128), wr_cnt <= 0. In fill mode, fill_val <= in_data.
- LOAD:
  - in_ready = 1.
  - On in_valid & in_ready: mem[addr] <= in_data, addr <= addr+1 mod 128, wr_cnt++, remaining--.
  - When the last word is accepted, go to DONE.
  - in_valid low stalls the job indefinitely with no timeout.
- FILL: writes fill_val once per cycle with no handshake. in_ready = 0. Goes to DONE after the last write.
- DONE: done = 1 for exactly one cycle, in_ready = 0, then IDLE.
- Wrap-around: base=120, len=16 writes 120..127, then 0..7. len=128 overwrites every entry exactly once.
- Read port:
  - Always active: rd_data <= mem[rd_addr] each cycle, independent of state.
  - Same-address read and write in the same cycle is read-first: the old word is returned and the new word is visible the next cycle.
- Reset:
  - Reset values: state IDLE, in_ready 0, busy 0, done 0, wr_cnt 0, rd_data 0, addr 0.
  - RAM contents are not reset.
  - Reset mid-job aborts the job. Words already written stay; no done pulse is issued.

## Timing
- Stream throughput: one word per cycle while in_valid stays high.
- Write latency: the word accepted at edge N is readable at edge N+1 (appears on rd_data at N+2).
- Stream job with len=L and in_valid held high:
  - start at edge 0.
  - Words accepted at edges 1..L.
  - done high in the cycle after edge L.
  - IDLE again after edge L+1.
- Fill job with len=L: writes at edges 1..L, done in the cycle after edge L.
- len=0: done in the cycle after the start edge; no writes.
- in_ready is a registered state decode. It does not depend combinationally on in_valid.
- wr_cnt holds its final value after DONE until the next accepted start.

## Structure
- Package ram_loader_pkg holds:
  - the state encoding constants (IDLE, LOAD, FILL, DONE);
  - DEPTH, ADDR_W, DATA_W;
  - the length clamp constant MAX_LEN=128.
- Sub-module ram_128x16: one synchronous write port, one synchronous read-first read port, no reset on the array.
- The top level holds the FSM, the address counter and the remaining counter.

## Test plan
- Stream: base=0, len=4, words 0x1111/0x2222/0x3333/0x4444 with in_valid held high. Expect done pulse 5 cycles after start and wr_cnt=4. Reading addresses 0..3 returns those words; address 4 is unchanged.
- Wrap: base=126, len=4, words 0xA0..0xA3. Expect mem[126]=0xA0, mem[127]=0xA1, mem[0]=0xA2, mem[1]=0xA3.
- Stall: base=10, len=3, in_valid low for 5 cycles between the 1st and 2nd word. Expect in_ready to stay high, no write during the gap, wr_cnt=3, done only after the 3rd word.
- Fill and clamp: fill=1, in_data=0xBEEF, base=5, len=200. Expect exactly 128 writes (all entries 0xBEEF), wr_cnt=128, done 129 cycles after start.
- Boundaries:
  - len=0 gives a done pulse one cycle after start and no RAM change.
  - start held high during LOAD is ignored.
  - Read and write to address 7 in the same cycle returns the old value, then the new one.
- Reset mid-job: rst_n low after 2 of 6 words. Expect all outputs at reset values, first 2 words retained, no done pulse, next job starts normally.

Source files
------------

// File: rtl/ram_loader_pkg.sv
// rtl/ram_loader_pkg.sv - shared constants, state encoding and length clamp for ram_loader
package ram_loader_pkg;
  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 7;
  localparam int DEPTH   = 2 ** ADDR_W;
  localparam int MAX_LEN = 128;

  typedef enum logic [1:0] {IDLE, LOAD, FILL, DONE} state_e;

  // Requests longer than the RAM are cut to one full pass over every entry.
  function automatic logic [7:0] clamp_len(input logic [7:0] req_len);
    return (int'(req_len) > MAX_LEN) ? 8'(MAX_LEN) : req_len;
  endfunction
endpackage

// File: rtl/ram_128x16.sv
// rtl/ram_128x16.sv - single write port, registered read-first read port; array is not reset
module ram_128x16 #(
  parameter int DATA_W = ram_loader_pkg::DATA_W,
  parameter int ADDR_W = ram_loader_pkg::ADDR_W,
  parameter int DEPTH  = ram_loader_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Non-blocking read of the pre-edge array gives read-first on an address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/ram_loader.sv
// rtl/ram_loader.sv - stream/fill loader FSM writing a 128x16 RAM with wrapping address
module ram_loader #(
  parameter int DATA_W = ram_loader_pkg::DATA_W,
  parameter int ADDR_W = ram_loader_pkg::ADDR_W,
  parameter int DEPTH  = ram_loader_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              fill,
  input  logic [ADDR_W-1:0] base,
  input  logic [7:0]        len,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic [7:0]        wr_cnt,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  import ram_loader_pkg::*;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        remaining_q;
  logic [7:0]        wr_cnt_q;
  logic [DATA_W-1:0] fill_val_q;
  logic              in_ready_q;
  logic              busy_q;
  logic              done_q;
  logic [7:0]        len_clamped;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;

  assign len_clamped = clamp_len(len);
  assign wr_en       = (in_ready_q && in_valid) || (state_q == FILL);
  assign wr_data     = (state_q == FILL) ? fill_val_q : in_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      wr_cnt_q    <= '0;
      fill_val_q  <= '0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            addr_q      <= base;
            remaining_q <= len_clamped;
            wr_cnt_q    <= '0;
            busy_q      <= 1'b1;
            if (fill) fill_val_q <= in_data;
            if (len_clamped == 8'd0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else if (fill) begin
              state_q <= FILL;
            end else begin
              state_q    <= LOAD;
              in_ready_q <= 1'b1;
            end
          end
        end
        LOAD, FILL: begin
          if (wr_en) begin
            addr_q      <= addr_q + ADDR_W'(1);
            wr_cnt_q    <= wr_cnt_q + 8'd1;
            remaining_q <= remaining_q - 8'd1;
            if (remaining_q == 8'd1) begin
              state_q    <= DONE;
              in_ready_q <= 1'b0;
              done_q     <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  ram_128x16 #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk    (clk),
    .rst_n  (rst_n),
    .we_i   (wr_en),
    .waddr_i(addr_q),
    .wdata_i(wr_data),
    .raddr_i(rd_addr),
    .rdata_o(rd_data)
  );

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign wr_cnt   = wr_cnt_q;
endmodule

// File: tb/tb_ram_loader.sv
// tb/tb_ram_loader.sv - directed and randomized bench for ram_loader against an array model
module tb_ram_loader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        fill = 1'b0;
  logic [6:0]  base = '0;
  logic [7:0]  len = '0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        busy;
  logic        done;
  logic [7:0]  wr_cnt;
  logic [6:0]  rd_addr = '0;
  logic [15:0] rd_data;

  int          n_pass = 0;
  int          n_total = 0;
  logic [15:0] ref_mem [128];
  bit          known [128];
  logic [15:0] wq [128];

  always #5 clk = ~clk;

  ram_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .fill(fill), .base(base), .len(len),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .busy(busy),
    .done(done), .wr_cnt(wr_cnt), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic mw(input logic [6:0] a, input logic [15:0] d);
    ref_mem[a] = d;
    known[a]   = 1'b1;
  endtask

  task automatic sweep(input string tag);
    for (int a = 0; a < 128; a++) begin
      rd_addr = 7'(a);
      step();
      if (known[a]) chk(tag, rd_data, ref_mem[a]);
    end
  endtask

  task automatic do_fill(input logic [6:0] b, input logic [7:0] l, input logic [15:0] v);
    int n;
    logic [15:0] e;
    bit k;
    n = (int'(l) > 128) ? 128 : int'(l);
    start = 1'b1; fill = 1'b1; base = b; len = l; in_data = v; in_valid = 1'b0;
    for (int kk = 0; kk <= n; kk++) begin
      e = ref_mem[rd_addr];
      k = known[rd_addr];
      step();
      if (kk == 0) begin
        start = 1'b0; fill = 1'b0; in_data = 16'($urandom); base = 7'($urandom);
        len = 8'($urandom); in_valid = 1'($urandom_range(0, 1));
      end
      if (k) chk("fill_rd", rd_data, e);
      if (kk > 0) mw(7'(int'(b) + kk - 1), v);
      chk("fill_done", done, kk == n);
      chk("fill_ready", in_ready, 0);
      chk("fill_busy", busy, 1);
    end
    chk("fill_wr_cnt", wr_cnt, n);
    step();
    chk("fill_done_end", done, 0);
    chk("fill_busy_end", busy, 0);
    chk("fill_wr_cnt_hold", wr_cnt, n);
    in_valid = 1'b0;
  endtask

  task automatic do_stream(input logic [6:0] b, input logic [7:0] l, input bit hold_start,
                           input int gap_at, input int gap_len);
    int n;
    logic [15:0] e;
    bit k;
    n = (int'(l) > 128) ? 128 : int'(l);
    start = 1'b1; fill = 1'b0; base = b; len = l; in_valid = 1'b0; in_data = 16'($urandom);
    e = ref_mem[rd_addr]; k = known[rd_addr];
    step();
    if (k) chk("ld_rd_start", rd_data, e);
    if (!hold_start) start = 1'b0;
    base = 7'($urandom); len = 8'($urandom);
    chk("ld_busy", busy, 1);
    chk("ld_ready", in_ready, n != 0);
    chk("ld_done_start", done, n == 0);
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          in_valid = 1'b0; in_data = 16'($urandom);
          e = ref_mem[rd_addr]; k = known[rd_addr];
          step();
          if (k) chk("stall_rd", rd_data, e);
          chk("stall_ready", in_ready, 1);
          chk("stall_done", done, 0);
          chk("stall_wr_cnt", wr_cnt, i);
        end
      end
      in_valid = 1'b1; in_data = wq[i];
      e = ref_mem[rd_addr]; k = known[rd_addr];
      step();
      if (k) chk("ld_rd", rd_data, e);
      mw(7'(int'(b) + i), wq[i]);
      chk("ld_done", done, i == n - 1);
    end
    in_valid = 1'b0;
    chk("ld_wr_cnt", wr_cnt, n);
    chk("ld_ready_done", in_ready, 0);
    start = 1'b0;
    e = ref_mem[rd_addr]; k = known[rd_addr];
    step();
    if (k) chk("ld_rd_end", rd_data, e);
    chk("ld_done_end", done, 0);
    chk("ld_busy_end", busy, 0);
    chk("ld_wr_cnt_hold", wr_cnt, n);
  endtask

  initial begin
    int nn;
    #22;
    chk("rst_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wr_cnt", wr_cnt, 0);
    chk("rst_rd_data", rd_data, 0);
    rst_n = 1'b1;
    step();

    // Fill with over-long length: exactly one pass over all 128 entries.
    rd_addr = 7'd0;
    do_fill(7'd5, 8'd200, 16'hBEEF);
    sweep("fill_mem");

    rd_addr = 7'd4;
    wq[0] = 16'h1111; wq[1] = 16'h2222; wq[2] = 16'h3333; wq[3] = 16'h4444;
    do_stream(7'd0, 8'd4, 1'b0, -1, 0);

    wq[0] = 16'h00A0; wq[1] = 16'h00A1; wq[2] = 16'h00A2; wq[3] = 16'h00A3;
    rd_addr = 7'd127;
    do_stream(7'd126, 8'd4, 1'b0, -1, 0);

    for (int i = 0; i < 3; i++) wq[i] = 16'($urandom);
    rd_addr = 7'd11;
    do_stream(7'd10, 8'd3, 1'b0, 1, 5);

    do_stream(7'd20, 8'd0, 1'b0, -1, 0);
    do_fill(7'd30, 8'd0, 16'h5A5A);

    for (int i = 0; i < 5; i++) wq[i] = 16'($urandom);
    do_stream(7'd50, 8'd5, 1'b1, -1, 0);

    rd_addr = 7'd7;
    wq[0] = 16'hC0DE;
    do_stream(7'd7, 8'd1, 1'b0, -1, 0);
    sweep("directed_mem");

    // Abort a 6-word job after 2 words.
    rd_addr = 7'd41;
    start = 1'b1; fill = 1'b0; base = 7'd40; len = 8'd6;
    step();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_data = 16'($urandom); in_valid = 1'b1;
      step();
      mw(7'(40 + i), in_data);
    end
    in_data = 16'($urandom);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_ready", in_ready, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_wr_cnt", wr_cnt, 0);
    chk("abort_rd_data", rd_data, 0);
    step();
    step();
    rst_n = 1'b1; in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("abort_no_done", done, 0);
    end
    sweep("abort_mem");

    for (int j = 0; j < 8; j++) begin
      rd_addr = 7'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        do_fill(7'($urandom), 8'($urandom_range(0, 150)), 16'($urandom));
      end else begin
        len = 8'($urandom_range(0, 140));
        nn = (int'(len) > 128) ? 128 : int'(len);
        for (int i = 0; i < 128; i++) wq[i] = 16'($urandom);
        do_stream(7'($urandom), len, 1'($urandom_range(0, 1)),
                  (nn > 0) ? $urandom_range(0, nn - 1) : -1, $urandom_range(0, 4));
      end
    end
    sweep("random_mem");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
